// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM, long-press and
// auto-repeat detection. All outputs are registered single-cycle pulses/levels.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter int unsigned REPEAT_CYCLES   = 3000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
  localparam int unsigned CW = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_RELEASE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] dcnt, dcnt_nx;
  logic [CW-1:0] hcnt, hcnt_nx;
  logic          long_done, long_done_nx;
  logic          s1, s2;
  logic          pressed;
  logic          level_nx, press_nx, release_nx, long_nx, repeat_nx;

  assign pressed = ~s2;

  always_comb begin
    state_nx     = state;
    dcnt_nx      = dcnt;
    hcnt_nx      = hcnt;
    long_done_nx = long_done;
    press_nx     = 1'b0;
    release_nx   = 1'b0;
    long_nx      = 1'b0;
    repeat_nx    = 1'b0;

    case (state)
      IDLE: begin
        if (pressed) begin
          state_nx = DB_PRESS;
          dcnt_nx  = ONE;
        end
      end

      DB_PRESS: begin
        if (!pressed) begin
          state_nx = IDLE;
          dcnt_nx  = '0;
        end else if (dcnt == DB_LAST) begin
          state_nx = HELD;
          press_nx = 1'b1;
          dcnt_nx  = '0;
          hcnt_nx  = '0;
        end else begin
          dcnt_nx = dcnt + ONE;
        end
      end

      HELD: begin
        if (!pressed) begin
          state_nx = DB_RELEASE;
          dcnt_nx  = ONE;
        end else if (hcnt == LONG_LAST) begin
          state_nx     = REPEAT;
          long_nx      = 1'b1;
          long_done_nx = 1'b1;
          hcnt_nx      = '0;
        end else begin
          hcnt_nx = hcnt + ONE;
        end
      end

      REPEAT: begin
        if (!pressed) begin
          state_nx = DB_RELEASE;
          dcnt_nx  = ONE;
        end else if (hcnt == REP_LAST) begin
          repeat_nx = 1'b1;
          hcnt_nx   = '0;
        end else begin
          hcnt_nx = hcnt + ONE;
        end
      end

      DB_RELEASE: begin
        // hcnt stays frozen here so a rejected release glitch only stalls the hold timer
        if (pressed) begin
          state_nx = long_done ? REPEAT : HELD;
          dcnt_nx  = '0;
        end else if (dcnt == DB_LAST) begin
          state_nx     = IDLE;
          release_nx   = 1'b1;
          dcnt_nx      = '0;
          hcnt_nx      = '0;
          long_done_nx = 1'b0;
        end else begin
          dcnt_nx = dcnt + ONE;
        end
      end

      default: begin
        state_nx     = IDLE;
        dcnt_nx      = '0;
        hcnt_nx      = '0;
        long_done_nx = 1'b0;
      end
    endcase

    level_nx = (state_nx == HELD) || (state_nx == REPEAT) || (state_nx == DB_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= 1'b1;
      s2            <= 1'b1;
      state         <= IDLE;
      dcnt          <= '0;
      hcnt          <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      s1            <= btn_n;
      s2            <= s1;
      state         <= state_nx;
      dcnt          <= dcnt_nx;
      hcnt          <= hcnt_nx;
      long_done     <= long_done_nx;
      btn_level     <= level_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      long_pulse    <= long_nx;
      repeat_pulse  <= repeat_nx;
    end
  end

endmodule
